iob_dp_ram_be_ctrl: RTL



---
 rtl/iob_dp_ram_be_pkg.sv | 29 ++
 rtl/iob_dp_ram_be_port_rsp.sv | 43 ++++
 rtl/iob_dp_ram_be_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/iob_dp_ram_be_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_dp_ram_be_pkg
// Description : Shared definitions for the dual-port byte-enable RAM
//               controller: controller state encoding, collision counter
//               width and the byte-column helper.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_dp_ram_be_pkg;

  // Width of the saturating write-collision counter.
  localparam int COLL_CNT_W = 16;

  // Byte columns for the default 32-bit data path; other widths use num_col().
  localparam int DEF_DATA_W = 32;
  localparam int NUM_COL    = DEF_DATA_W / 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of byte lanes in a word of the given width.
  function automatic int num_col(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_dp_ram_be_port_rsp.sv
`default_nettype none
// ============================================================================
// Module      : iob_dp_ram_be_port_rsp
// Description : Per-port read response. Registers the read-accept strobe into
//               a one-cycle rvalid and keeps the last returned word so rdata
//               stays stable between responses.
// Ports       : clk, rst       - clock, async active-high reset
//               i_rd_acc       - read accepted this cycle
//               i_dout         - RAM read data (valid in the rvalid cycle)
//               o_rvalid       - one-cycle read response strobe
//               o_rdata        - live RAM data during rvalid, else held word
// Revision    : 1.0 - initial release
// ============================================================================
module iob_dp_ram_be_port_rsp #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_acc,
  input  logic [DATA_W-1:0] i_dout,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  logic              r_rvalid;
  logic [DATA_W-1:0] r_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_rvalid <= i_rd_acc;
      if (r_rvalid) r_hold <= i_dout;
    end
  end

  // RAM data is only meaningful in the rvalid cycle; afterwards show the copy.
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rvalid ? i_dout : r_hold;

endmodule
`default_nettype wire

// File: rtl/iob_dp_ram_be_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iob_dp_ram_be_ctrl
// Description : Converts two IOb-native request ports into dual-port
//               byte-enable RAM controls. Optionally zero-fills the memory
//               through RAM port A after reset, masks port B bytes on
//               same-address write collisions (port A wins) and counts
//               overlapping collisions.
// Ports       : clk, rst                  - clock, async active-high reset
//               init_done, coll_cnt       - status
//               a_*/b_* (valid, addr, wdata, wstrb, ready, rdata, rvalid)
//                                         - IOb-native request ports
//               ram_{en,we,addr,din}_a/b  - RAM controls
//               ram_dout_a/b              - RAM read data (read-first, 1 cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module iob_dp_ram_be_ctrl
  import iob_dp_ram_be_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int INIT_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_done,
  output logic [COLL_CNT_W-1:0]   coll_cnt,
  input  logic                    a_valid,
  input  logic [ADDR_W-1:0]       a_addr,
  input  logic [DATA_W-1:0]       a_wdata,
  input  logic [DATA_W/8-1:0]     a_wstrb,
  output logic                    a_ready,
  output logic [DATA_W-1:0]       a_rdata,
  output logic                    a_rvalid,
  input  logic                    b_valid,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic [DATA_W-1:0]       b_wdata,
  input  logic [DATA_W/8-1:0]     b_wstrb,
  output logic                    b_ready,
  output logic [DATA_W-1:0]       b_rdata,
  output logic                    b_rvalid,
  output logic                    ram_en_a,
  output logic [DATA_W/8-1:0]     ram_we_a,
  output logic [ADDR_W-1:0]       ram_addr_a,
  output logic [DATA_W-1:0]       ram_din_a,
  input  logic [DATA_W-1:0]       ram_dout_a,
  output logic                    ram_en_b,
  output logic [DATA_W/8-1:0]     ram_we_b,
  output logic [ADDR_W-1:0]       ram_addr_b,
  output logic [DATA_W-1:0]       ram_din_b,
  input  logic [DATA_W-1:0]       ram_dout_b
);

  localparam int NCOL = num_col(DATA_W);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_init_cnt;
  logic [ADDR_W-1:0]     w_init_cnt_nxt;
  logic [COLL_CNT_W-1:0] r_coll_cnt;

  logic w_run;
  logic w_init_wr;
  logic w_a_go;
  logic w_b_go;
  logic w_coll;
  logic w_overlap;

  // --------------------------------------------------------------------------
  // Controller FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        if (INIT_ZERO == 0) begin
          w_state_nxt = ST_RUN;
        end else if (r_init_cnt == {ADDR_W{1'b1}}) begin
          // Last word written this cycle; counter is left parked, never wraps.
          w_state_nxt = ST_RUN;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 1'b1;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_run     = (r_state == ST_RUN);
  // rst gating keeps the RAM quiet for the whole time reset is held.
  assign w_init_wr = (r_state == ST_INIT) && (INIT_ZERO != 0) && !rst;

  assign init_done = w_run;
  assign a_ready   = w_run;
  assign b_ready   = w_run;

  assign w_a_go = w_run && a_valid && !rst;
  assign w_b_go = w_run && b_valid && !rst;

  // --------------------------------------------------------------------------
  // Write collision: both ports write the same word in the same cycle.
  // --------------------------------------------------------------------------
  assign w_coll    = w_a_go && w_b_go && (|a_wstrb) && (|b_wstrb) && (a_addr == b_addr);
  assign w_overlap = w_coll && (|(a_wstrb & b_wstrb));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll_cnt <= '0;
    end else if (w_overlap && (r_coll_cnt != {COLL_CNT_W{1'b1}})) begin
      r_coll_cnt <= r_coll_cnt + 1'b1;
    end
  end

  assign coll_cnt = r_coll_cnt;

  // --------------------------------------------------------------------------
  // RAM port A: zero-fill engine during INIT, request port A during RUN
  // --------------------------------------------------------------------------
  assign ram_en_a   = w_init_wr || w_a_go;
  assign ram_we_a   = w_init_wr ? {NCOL{1'b1}} : (w_a_go ? a_wstrb : '0);
  assign ram_addr_a = w_init_wr ? r_init_cnt : a_addr;
  assign ram_din_a  = w_init_wr ? '0 : a_wdata;

  // --------------------------------------------------------------------------
  // RAM port B: port A owns overlapping bytes on a collision
  // --------------------------------------------------------------------------
  assign ram_en_b   = w_b_go;
  assign ram_we_b   = !w_b_go ? '0 : (w_coll ? (b_wstrb & ~a_wstrb) : b_wstrb);
  assign ram_addr_b = b_addr;
  assign ram_din_b  = b_wdata;

  // --------------------------------------------------------------------------
  // Read responses
  // --------------------------------------------------------------------------
  iob_dp_ram_be_port_rsp #(
    .DATA_W (DATA_W)
  ) u_rsp_a (
    .clk      (clk),
    .rst      (rst),
    .i_rd_acc (w_a_go && (a_wstrb == '0)),
    .i_dout   (ram_dout_a),
    .o_rvalid (a_rvalid),
    .o_rdata  (a_rdata)
  );

  iob_dp_ram_be_port_rsp #(
    .DATA_W (DATA_W)
  ) u_rsp_b (
    .clk      (clk),
    .rst      (rst),
    .i_rd_acc (w_b_go && (b_wstrb == '0)),
    .i_dout   (ram_dout_b),
    .o_rvalid (b_rvalid),
    .o_rdata  (b_rdata)
  );

endmodule
`default_nettype wire
